// File: rtl/opr_wakeup_buf.sv
// Operand wakeup buffer: DEPTH operand slots that wait on tagged result
// broadcasts, capture the lowest-channel unkilled hit, and feed one issue port.

module opr_wakeup_match #(
  parameter int DATA_LEN = 32,
  parameter int RRF_SEL  = 6,
  parameter int NUM_CH   = 7
) (
  input  logic [RRF_SEL-1:0]         tag,
  input  logic [NUM_CH-1:0]          ex_valid,
  input  logic [NUM_CH-1:0]          ex_kill,
  input  logic [NUM_CH*RRF_SEL-1:0]  ex_dst,
  input  logic [NUM_CH*DATA_LEN-1:0] ex_rslt,
  output logic                       hit,
  output logic [DATA_LEN-1:0]        rslt
);
  // Walk from the top channel down so the lowest matching channel lands last.
  always_comb begin
    hit  = 1'b0;
    rslt = '0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (ex_valid[c] && !ex_kill[c] && ex_dst[c*RRF_SEL +: RRF_SEL] == tag) begin
        hit  = 1'b1;
        rslt = ex_rslt[c*DATA_LEN +: DATA_LEN];
      end
    end
  end
endmodule

module opr_wakeup_entry #(
  parameter int DATA_LEN = 32,
  parameter int RRF_SEL  = 6,
  parameter int NUM_CH   = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       load,
  input  logic                       load_wait,
  input  logic [DATA_LEN-1:0]        load_opr,
  input  logic                       free,
  input  logic [NUM_CH-1:0]          ex_valid,
  input  logic [NUM_CH-1:0]          ex_kill,
  input  logic [NUM_CH*RRF_SEL-1:0]  ex_dst,
  input  logic [NUM_CH*DATA_LEN-1:0] ex_rslt,
  output logic                       busy,
  output logic                       ready,
  output logic                       wait_nxt,
  output logic                       wake,
  output logic [DATA_LEN-1:0]        wake_rslt,
  output logic [DATA_LEN-1:0]        opr
);
  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} st_e;

  st_e                 state_q, state_d;
  logic [DATA_LEN-1:0] opr_q, opr_d;
  logic                m_hit;

  opr_wakeup_match #(.DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL), .NUM_CH(NUM_CH)) u_match (
    .tag(opr_q[RRF_SEL-1:0]), .ex_valid(ex_valid), .ex_kill(ex_kill),
    .ex_dst(ex_dst), .ex_rslt(ex_rslt), .hit(m_hit), .rslt(wake_rslt)
  );

  assign wake = (state_q == S_WAIT) && m_hit;

  // A load already accounts for any concurrent free of this slot.
  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (load) begin
      state_d = load_wait ? S_WAIT : S_READY;
      opr_d   = load_opr;
    end else begin
      if (wake) begin
        state_d = S_READY;
        opr_d   = wake_rslt;
      end
      if (free) state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      opr_q   <= '0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
    end
  end

  assign busy     = (state_q != S_EMPTY);
  assign ready    = (state_q == S_READY);
  assign wait_nxt = (state_d == S_WAIT);
  assign opr      = opr_q;
endmodule

module opr_wakeup_buf #(
  parameter int DATA_LEN = 32,
  parameter int RRF_SEL  = 6,
  parameter int NUM_CH   = 7,
  parameter int DEPTH    = 8,
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_en,
  input  logic [IDX_W-1:0]           alloc_idx,
  input  logic [DATA_LEN-1:0]        alloc_opr,
  input  logic                       alloc_rdy,
  input  logic [NUM_CH-1:0]          ex_valid,
  input  logic [NUM_CH-1:0]          ex_kill,
  input  logic [NUM_CH*RRF_SEL-1:0]  ex_dst,
  input  logic [NUM_CH*DATA_LEN-1:0] ex_rslt,
  input  logic                       issue_en,
  input  logic [IDX_W-1:0]           issue_idx,
  input  logic                       flush,
  output logic [DEPTH-1:0]           busy,
  output logic [DEPTH-1:0]           resolved,
  output logic [DATA_LEN-1:0]        src_out,
  output logic                       src_ok,
  output logic [IDX_W:0]             wait_cnt,
  output logic                       alloc_err
);
  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]               busy_v, rdy_v, wnxt_v, wake_v, load_v, free_v;
  logic [DEPTH-1:0][DATA_LEN-1:0] opr_v, wrslt_v;
  logic                           a_hit, alloc_in, issue_in, issue_fire, alloc_free;
  logic                           alloc_go, load_wait;
  logic [DATA_LEN-1:0]            a_rslt, load_opr;
  logic [IDX_W:0]                 wait_cnt_q, wait_cnt_d;
  logic                           alloc_err_q, alloc_err_d;

  // An incoming operand tag can be woken by a result broadcast in the same cycle.
  opr_wakeup_match #(.DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL), .NUM_CH(NUM_CH)) u_amatch (
    .tag(alloc_opr[RRF_SEL-1:0]), .ex_valid(ex_valid), .ex_kill(ex_kill),
    .ex_dst(ex_dst), .ex_rslt(ex_rslt), .hit(a_hit), .rslt(a_rslt)
  );

  assign alloc_in = ({1'b0, alloc_idx} < DEPTH_W);
  assign issue_in = ({1'b0, issue_idx} < DEPTH_W);

  always_comb begin
    src_out = '0;
    src_ok  = 1'b0;
    if (issue_in) begin
      src_out = opr_v[issue_idx];
      if (rdy_v[issue_idx]) begin
        src_ok = 1'b1;
      end else if (wake_v[issue_idx]) begin
        src_out = wrslt_v[issue_idx];
        src_ok  = 1'b1;
      end
    end
  end

  assign issue_fire  = issue_en && src_ok;
  assign alloc_free  = alloc_in && (!busy_v[alloc_idx] || (issue_fire && issue_idx == alloc_idx));
  assign alloc_go    = alloc_en && alloc_in && !flush && alloc_free;
  assign alloc_err_d = alloc_en && alloc_in && !flush && !alloc_free;
  assign load_wait   = !alloc_rdy && !a_hit;
  assign load_opr    = (!alloc_rdy && a_hit) ? a_rslt : alloc_opr;

  always_comb begin
    load_v     = '0;
    free_v     = '0;
    wait_cnt_d = '0;
    for (int e = 0; e < DEPTH; e++) begin
      load_v[e]  = alloc_go && (alloc_idx == IDX_W'(e));
      free_v[e]  = issue_fire && (issue_idx == IDX_W'(e));
      wait_cnt_d = wait_cnt_d + (IDX_W+1)'(wnxt_v[e]);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    opr_wakeup_entry #(.DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL), .NUM_CH(NUM_CH)) u_ent (
      .clk(clk), .reset(reset), .flush(flush), .load(load_v[g]), .load_wait(load_wait),
      .load_opr(load_opr), .free(free_v[g]), .ex_valid(ex_valid), .ex_kill(ex_kill),
      .ex_dst(ex_dst), .ex_rslt(ex_rslt), .busy(busy_v[g]), .ready(rdy_v[g]),
      .wait_nxt(wnxt_v[g]), .wake(wake_v[g]), .wake_rslt(wrslt_v[g]), .opr(opr_v[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      alloc_err_q <= alloc_err_d;
    end
  end

  assign busy      = busy_v;
  assign resolved  = rdy_v;
  assign wait_cnt  = wait_cnt_q;
  assign alloc_err = alloc_err_q;
endmodule
